// File: rtl/ysyx_24110006_uart_warb.sv
// Two-master AXI4-Lite write-channel arbiter in front of the UART; one transaction at a time.
// Define YSYX_24110006_WARB_RR_EN for round-robin ties; otherwise master 0 has fixed priority.
`timescale 1ns/1ps

module ysyx_24110006_uart_warb (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_m0_axi_awaddr,
  input  logic        i_m0_axi_awvalid,
  output logic        o_m0_axi_awready,
  input  logic [31:0] i_m0_axi_wdata,
  input  logic [7:0]  i_m0_axi_wstrb,
  input  logic        i_m0_axi_wvalid,
  output logic        o_m0_axi_wready,
  output logic [1:0]  o_m0_axi_bresp,
  output logic        o_m0_axi_bvalid,
  input  logic        i_m0_axi_bready,
  input  logic [31:0] i_m1_axi_awaddr,
  input  logic        i_m1_axi_awvalid,
  output logic        o_m1_axi_awready,
  input  logic [31:0] i_m1_axi_wdata,
  input  logic [7:0]  i_m1_axi_wstrb,
  input  logic        i_m1_axi_wvalid,
  output logic        o_m1_axi_wready,
  output logic [1:0]  o_m1_axi_bresp,
  output logic        o_m1_axi_bvalid,
  input  logic        i_m1_axi_bready,
  output logic [31:0] o_axi_awaddr,
  output logic        o_axi_awvalid,
  input  logic        i_axi_awready,
  output logic [31:0] o_axi_wdata,
  output logic [7:0]  o_axi_wstrb,
  output logic        o_axi_wvalid,
  input  logic        i_axi_wready,
  input  logic [1:0]  i_axi_bresp,
  input  logic        i_axi_bvalid,
  output logic        o_axi_bready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        req0, req1, pick;
  logic [31:0] sel_awaddr, sel_wdata;
  logic [7:0]  sel_wstrb;
  logic        sel_awvalid, sel_wvalid, sel_bready;
  logic        awready_c, wready_c, bvalid_c;
  logic [1:0]  bresp_c;
  logic        aw_hs, w_hs, b_hs;

  assign req0 = i_m0_axi_awvalid;
  assign req1 = i_m1_axi_awvalid;

`ifdef YSYX_24110006_WARB_RR_EN
  // Tie goes to whoever was not served last; a lone requester always wins.
  assign pick = (req0 & req1) ? ~last_q : req1;
`else
  assign pick = ~req0;
`endif

  assign sel_awaddr  = gnt_q ? i_m1_axi_awaddr  : i_m0_axi_awaddr;
  assign sel_awvalid = gnt_q ? i_m1_axi_awvalid : i_m0_axi_awvalid;
  assign sel_wdata   = gnt_q ? i_m1_axi_wdata   : i_m0_axi_wdata;
  assign sel_wstrb   = gnt_q ? i_m1_axi_wstrb   : i_m0_axi_wstrb;
  assign sel_wvalid  = gnt_q ? i_m1_axi_wvalid  : i_m0_axi_wvalid;
  assign sel_bready  = gnt_q ? i_m1_axi_bready  : i_m0_axi_bready;

  // State and bookkeeping registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state: grant is latched in IDLE and held until the B handshake
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          gnt_d     = pick;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (b_hs) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: forward the granted master only; everything else reads zero
  always_comb begin
    o_axi_awaddr  = 32'd0;
    o_axi_awvalid = 1'b0;
    o_axi_wdata   = 32'd0;
    o_axi_wstrb   = 8'd0;
    o_axi_wvalid  = 1'b0;
    o_axi_bready  = 1'b0;
    awready_c     = 1'b0;
    wready_c      = 1'b0;
    bvalid_c      = 1'b0;
    bresp_c       = 2'b00;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    b_hs          = 1'b0;
    case (state_q)
      ST_ADDR: begin
        o_axi_awaddr  = sel_awaddr;
        o_axi_wdata   = sel_wdata;
        o_axi_wstrb   = sel_wstrb;
        o_axi_awvalid = sel_awvalid & ~aw_done_q;
        o_axi_wvalid  = sel_wvalid & ~w_done_q;
        awready_c     = i_axi_awready & ~aw_done_q;
        wready_c      = i_axi_wready & ~w_done_q;
        aw_hs         = sel_awvalid & ~aw_done_q & i_axi_awready;
        w_hs          = sel_wvalid & ~w_done_q & i_axi_wready;
      end
      ST_RESP: begin
        o_axi_awaddr  = sel_awaddr;
        o_axi_wdata   = sel_wdata;
        o_axi_wstrb   = sel_wstrb;
        o_axi_bready  = sel_bready;
        bvalid_c      = i_axi_bvalid;
        bresp_c       = i_axi_bresp;
        b_hs          = i_axi_bvalid & sel_bready;
      end
      default: ;
    endcase
    o_m0_axi_awready = awready_c & ~gnt_q;
    o_m1_axi_awready = awready_c & gnt_q;
    o_m0_axi_wready  = wready_c & ~gnt_q;
    o_m1_axi_wready  = wready_c & gnt_q;
    o_m0_axi_bvalid  = bvalid_c & ~gnt_q;
    o_m1_axi_bvalid  = bvalid_c & gnt_q;
    o_m0_axi_bresp   = gnt_q ? 2'b00 : bresp_c;
    o_m1_axi_bresp   = gnt_q ? bresp_c : 2'b00;
  end

endmodule

// File: tb/tb_ysyx_24110006_uart_warb.sv
// Self-checking bench for ysyx_24110006_uart_warb: vector table, directed corner cases and
// randomized traffic checked against a transaction-level arbitration model.
`timescale 1ns/1ps

module tb_ysyx_24110006_uart_warb;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    int          wdly;
    int          gap;
    int          bhold;
  } txn_t;

  typedef struct {
    logic aw0, w0, aw1, w1, awr, wr;
    logic [5:0]  exp;
    logic [31:0] exp_addr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m_addr [2];
  logic [31:0] m_data [2];
  logic [7:0]  m_strb [2];
  logic [1:0]  m_awv, m_wv, m_br;
  logic [1:0]  o_awr, o_wr, o_bv;
  logic [3:0]  o_bresp;
  logic [31:0] s_awaddr, s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_awv, s_wv, s_br;
  logic        s_awr, s_wr, s_bv;
  logic [1:0]  s_bresp;

  ysyx_24110006_uart_warb dut (
    .i_clock(clk), .i_reset(rst),
    .i_m0_axi_awaddr(m_addr[0]), .i_m0_axi_awvalid(m_awv[0]), .o_m0_axi_awready(o_awr[0]),
    .i_m0_axi_wdata(m_data[0]), .i_m0_axi_wstrb(m_strb[0]), .i_m0_axi_wvalid(m_wv[0]),
    .o_m0_axi_wready(o_wr[0]), .o_m0_axi_bresp(o_bresp[1:0]), .o_m0_axi_bvalid(o_bv[0]),
    .i_m0_axi_bready(m_br[0]),
    .i_m1_axi_awaddr(m_addr[1]), .i_m1_axi_awvalid(m_awv[1]), .o_m1_axi_awready(o_awr[1]),
    .i_m1_axi_wdata(m_data[1]), .i_m1_axi_wstrb(m_strb[1]), .i_m1_axi_wvalid(m_wv[1]),
    .o_m1_axi_wready(o_wr[1]), .o_m1_axi_bresp(o_bresp[3:2]), .o_m1_axi_bvalid(o_bv[1]),
    .i_m1_axi_bready(m_br[1]),
    .o_axi_awaddr(s_awaddr), .o_axi_awvalid(s_awv), .i_axi_awready(s_awr),
    .o_axi_wdata(s_wdata), .o_axi_wstrb(s_wstrb), .o_axi_wvalid(s_wv), .i_axi_wready(s_wr),
    .i_axi_bresp(s_bresp), .i_axi_bvalid(s_bv), .o_axi_bready(s_br)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Master scripts and progress
  txn_t mt [2][16];
  int   mn [2], mi [2];
  txn_t cur [2];
  bit   act [2], w_done_m [2];
  int   wcnt [2], gapc [2], bh [2];
  // UART-side responder
  bit   slv_rand, slv_ready, s_got_aw, s_got_w;
  int   s_bcnt;
  // Handshakes seen in the current cycle, retired after the next edge
  bit   hs_aw [2], hs_w [2], hs_b [2];
  bit   hs_saw, hs_sw, hs_sb;
  // Reference: who owns the port and how far the transaction has progressed
  bit   busy, owner, r_aw_acc, r_w_acc, r_last;
  // Observations
  logic [31:0] wlog [$];
  int   aw_cnt, cyc, done_cnt, aw_hs_cyc, w_hs_cyc;
  int   bv_cycles [2], b_hs_cyc [2], first_awr_cyc [2];

  // Winner among the requesters under the configured policy.
  function automatic bit winner(input bit r0, input bit r1, input bit lst);
`ifdef YSYX_24110006_WARB_RR_EN
    if (r0 && r1) return (lst == 1'b1) ? 1'b0 : 1'b1;
`endif
    return r0 ? 1'b0 : 1'b1;
  endfunction

  task automatic clear_env();
    for (int m = 0; m < 2; m++) begin
      mn[m] = 0; mi[m] = 0; act[m] = 0; w_done_m[m] = 0; wcnt[m] = 0; gapc[m] = 0; bh[m] = 0;
      hs_aw[m] = 0; hs_w[m] = 0; hs_b[m] = 0;
      bv_cycles[m] = 0; b_hs_cyc[m] = -1; first_awr_cyc[m] = -1;
    end
    m_awv = 2'b00; m_wv = 2'b00; m_br = 2'b00;
    s_awr = 0; s_wr = 0; s_bv = 0; s_bresp = 2'b00;
    s_got_aw = 0; s_got_w = 0; s_bcnt = 0;
    hs_saw = 0; hs_sw = 0; hs_sb = 0;
    busy = 0; owner = 0; r_aw_acc = 0; r_w_acc = 0; r_last = 1;
    wlog.delete(); aw_cnt = 0; done_cnt = 0; aw_hs_cyc = -1; w_hs_cyc = -1;
  endtask

  // One-cycle synchronous reset, then all outputs must read zero.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    clear_env();
    @(posedge clk); #1;
    rst = 0;
    #3;
    chk("reset_ctrl", 64'({o_awr, o_wr, o_bv, o_bresp, s_awv, s_wv, s_br}), 64'd0);
    chk("reset_payload", 64'({s_awaddr, s_wstrb}), 64'd0);
    chk("reset_wdata", 64'(s_wdata), 64'd0);
  endtask

  task automatic add_txn(input int m, input logic [31:0] a, input logic [31:0] d,
                         input logic [7:0] s, input int wdly, input int gap, input int bhold);
    mt[m][mn[m]].addr = a; mt[m][mn[m]].data = d; mt[m][mn[m]].strb = s;
    mt[m][mn[m]].wdly = wdly; mt[m][mn[m]].gap = gap; mt[m][mn[m]].bhold = bhold;
    if (mn[m] == 0) gapc[m] = gap;
    mn[m]++;
  endtask

  task automatic cycle();
    bit resp, in_addr, in_resp, e_awv, e_wv, e_awr, e_wr, e_bv, e_br, r0, r1;
    logic [1:0] place, e_bresp;
    @(posedge clk); #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (hs_aw[m]) m_awv[m] = 0;
      if (hs_w[m]) begin m_wv[m] = 0; w_done_m[m] = 1; end
      if (hs_b[m]) begin
        act[m] = 0; done_cnt++;
        gapc[m] = (mi[m] < mn[m]) ? mt[m][mi[m]].gap : 0;
      end
      hs_aw[m] = 0; hs_w[m] = 0; hs_b[m] = 0;
    end
    if (hs_saw) s_got_aw = 1;
    if (hs_sw)  s_got_w = 1;
    if (hs_sb) begin
      s_bv = 0; s_got_aw = 0; s_got_w = 0;
      s_bcnt = slv_rand ? int'($urandom_range(0, 3)) : 0;
    end
    hs_saw = 0; hs_sw = 0; hs_sb = 0;
    for (int m = 0; m < 2; m++) begin
      if (!act[m] && mi[m] < mn[m]) begin
        if (gapc[m] > 0) gapc[m]--;
        else begin
          cur[m] = mt[m][mi[m]]; mi[m]++; act[m] = 1; w_done_m[m] = 0;
          m_awv[m] = 1; m_wv[m] = 0;
          m_addr[m] = cur[m].addr; m_data[m] = cur[m].data; m_strb[m] = cur[m].strb;
          wcnt[m] = cur[m].wdly; bh[m] = cur[m].bhold;
        end
      end
      if (act[m] && !w_done_m[m] && !m_wv[m]) begin
        if (wcnt[m] == 0) m_wv[m] = 1;
        else wcnt[m]--;
      end
      if (!act[m]) begin
        m_addr[m] = $urandom; m_data[m] = $urandom; m_strb[m] = 8'($urandom);
        m_wv[m] = slv_rand && ($urandom_range(0, 3) == 0);
      end
      m_br[m] = (bh[m] == 0);
    end
    s_awr = slv_rand ? 1'($urandom_range(0, 1)) : slv_ready;
    s_wr  = slv_rand ? 1'($urandom_range(0, 1)) : slv_ready;
    if (!s_bv) s_bresp = slv_rand ? 2'($urandom) : 2'b00;
    if (s_got_aw && s_got_w && !s_bv) begin
      if (s_bcnt == 0) s_bv = 1;
      else s_bcnt--;
    end
    #3;
    resp    = r_aw_acc & r_w_acc;
    in_addr = busy & !resp;
    in_resp = busy & resp;
    e_awv   = in_addr & m_awv[owner] & !r_aw_acc;
    e_wv    = in_addr & m_wv[owner] & !r_w_acc;
    e_awr   = in_addr & s_awr & !r_aw_acc;
    e_wr    = in_addr & s_wr & !r_w_acc;
    e_bv    = in_resp & s_bv;
    e_br    = in_resp & m_br[owner];
    e_bresp = in_resp ? s_bresp : 2'b00;
    place   = owner ? 2'b10 : 2'b01;
    chk("m_awready", 64'(o_awr), 64'(e_awr ? place : 2'b00));
    chk("m_wready", 64'(o_wr), 64'(e_wr ? place : 2'b00));
    chk("m_bvalid", 64'(o_bv), 64'(e_bv ? place : 2'b00));
    chk("m_bresp", 64'(o_bresp), 64'(owner ? {e_bresp, 2'b00} : {2'b00, e_bresp}));
    chk("s_valids", 64'({s_awv, s_wv, s_br}), 64'({e_awv, e_wv, e_br}));
    if (!busy) begin
      chk("idle_awaddr", 64'(s_awaddr), 64'd0);
      chk("idle_wpayload", 64'({s_wdata, s_wstrb}), 64'd0);
    end
    if (s_awv) chk("s_awaddr", 64'(s_awaddr), 64'(cur[owner].addr));
    if (s_wv)  chk("s_wpayload", 64'({s_wdata, s_wstrb}), 64'({cur[owner].data, cur[owner].strb}));
    for (int m = 0; m < 2; m++) begin
      hs_aw[m] = m_awv[m] & o_awr[m];
      hs_w[m]  = m_wv[m] & o_wr[m];
      hs_b[m]  = o_bv[m] & m_br[m];
      if (o_bv[m]) begin
        bv_cycles[m]++;
        if (!m_br[m] && bh[m] > 0) bh[m]--;
      end
      if (o_awr[m] && first_awr_cyc[m] < 0) first_awr_cyc[m] = cyc;
      if (hs_b[m]) b_hs_cyc[m] = cyc;
    end
    hs_saw = s_awv & s_awr;
    hs_sw  = s_wv & s_wr;
    hs_sb  = s_bv & s_br;
    if (hs_saw) begin aw_cnt++; aw_hs_cyc = cyc; end
    if (hs_sw)  begin wlog.push_back(s_wdata); w_hs_cyc = cyc; end
    r0 = m_awv[0]; r1 = m_awv[1];
    if (!busy) begin
      if (r0 || r1) begin
        busy = 1; owner = winner(r0, r1, r_last); r_aw_acc = 0; r_w_acc = 0;
      end
    end else if (!resp) begin
      if (e_awv && s_awr) r_aw_acc = 1;
      if (e_wv && s_wr)   r_w_acc = 1;
    end else if (s_bv && m_br[owner]) begin
      busy = 0; r_last = owner;
    end
  endtask

  task automatic run_all(input int max);
    int n = 0;
    while ((act[0] || act[1] || mi[0] < mn[0] || mi[1] < mn[1]) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_within_budget", 64'(n < max), 64'd1);
    cycle();
  endtask

  vec_t tv [5];
  logic [31:0] order;

  initial begin
    rst = 1;
    m_addr[0] = '0; m_addr[1] = '0; m_data[0] = '0; m_data[1] = '0;
    m_strb[0] = '0; m_strb[1] = '0;
    slv_rand = 0; slv_ready = 1; cyc = 0;
    clear_env();
    tv[0] = '{1, 1, 0, 0, 1, 1, 6'b111100, 32'h1000_0000};
    tv[1] = '{0, 0, 1, 1, 1, 0, 6'b110010, 32'h2000_0001};
    tv[2] = '{1, 0, 1, 1, 0, 1, 6'b100100, 32'h1000_0002};
    tv[3] = '{0, 1, 0, 1, 1, 1, 6'b000000, 32'h0000_0000};
    tv[4] = '{0, 1, 1, 0, 1, 1, 6'b100011, 32'h2000_0004};
    repeat (3) @(posedge clk);

    // First-grant vectors from reset; each ends in a reset while in ADDR
    for (int i = 0; i < 5; i++) begin
      do_reset();
      @(posedge clk); #1;
      m_addr[0] = 32'h1000_0000 + 32'(i); m_addr[1] = 32'h2000_0000 + 32'(i);
      m_awv = {tv[i].aw1, tv[i].aw0}; m_wv = {tv[i].w1, tv[i].w0};
      s_awr = tv[i].awr; s_wr = tv[i].wr;
      #3;
      chk("tv_idle_ctrl", 64'({s_awv, s_wv, o_awr[0], o_wr[0], o_awr[1], o_wr[1]}), 64'd0);
      chk("tv_idle_addr", 64'(s_awaddr), 64'd0);
      @(posedge clk); #4;
      chk("tv_grant_ctrl", 64'({s_awv, s_wv, o_awr[0], o_wr[0], o_awr[1], o_wr[1]}), 64'(tv[i].exp));
      chk("tv_grant_addr", 64'(s_awaddr), 64'(tv[i].exp_addr));
    end

    // Single 'A' from m0
    do_reset();
    add_txn(0, 32'hA000_03F8, 32'h0000_0041, 8'h01, 0, 0, 0);
    run_all(50);
    chk("single_writes", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) chk("single_data", 64'(wlog[0]), 64'h41);
    chk("single_aw_count", 64'(aw_cnt), 64'd1);
    chk("single_m0_bvalid_cycles", 64'(bv_cycles[0]), 64'd1);
    chk("single_m1_bvalid_cycles", 64'(bv_cycles[1]), 64'd0);

    // Simultaneous requests, each master re-requesting once
    do_reset();
    add_txn(0, 32'hA000_03F8, 32'h58, 8'h01, 0, 0, 0);
    add_txn(0, 32'hA000_03F8, 32'h58, 8'h01, 0, 0, 0);
    add_txn(1, 32'hA000_03F8, 32'h59, 8'h01, 0, 0, 0);
    add_txn(1, 32'hA000_03F8, 32'h59, 8'h01, 0, 0, 0);
    run_all(100);
    chk("tie_writes", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) begin
      order = {wlog[0][7:0], wlog[1][7:0], wlog[2][7:0], wlog[3][7:0]};
`ifdef YSYX_24110006_WARB_RR_EN
      chk("tie_order", 64'(order), 64'h5859_5859);
`else
      chk("tie_order", 64'(order), 64'h5858_5959);
`endif
    end

    // m1 presents W three cycles after AW
    do_reset();
    add_txn(1, 32'hA000_0010, 32'h0000_0077, 8'h0F, 3, 0, 0);
    run_all(50);
    chk("ooo_aw_count", 64'(aw_cnt), 64'd1);
    chk("ooo_writes", 64'(wlog.size()), 64'd1);
    chk("ooo_w_after_aw", 64'(w_hs_cyc - aw_hs_cyc), 64'd2);

    // m0 holds bready low for 5 cycles while m1 waits
    do_reset();
    add_txn(0, 32'hA000_0020, 32'h0000_0031, 8'h01, 0, 0, 5);
    add_txn(1, 32'hA000_0024, 32'h0000_0032, 8'h01, 0, 1, 0);
    run_all(80);
    chk("bp_m0_bvalid_cycles", 64'(bv_cycles[0]), 64'd6);
    chk("bp_m1_grant_delay", 64'(first_awr_cyc[1] - b_hs_cyc[0]), 64'd2);
    chk("bp_writes", 64'(wlog.size()), 64'd2);

    // Reset while m1 holds the grant; the next tie must go to m0
    do_reset();
    add_txn(0, 32'hA000_0030, 32'h0000_0011, 8'h01, 0, 0, 0);
    run_all(50);
    slv_ready = 0;
    add_txn(1, 32'hA000_0034, 32'h0000_0022, 8'h01, 0, 0, 0);
    cycle();
    cycle();
    chk("rst_m1_granted", 64'({s_awv, s_awaddr}), 64'({1'b1, 32'hA000_0034}));
    do_reset();
    slv_ready = 1;
    add_txn(0, 32'hA000_0038, 32'h0000_0030, 8'h01, 0, 0, 0);
    add_txn(1, 32'hA000_003C, 32'h0000_0031, 8'h01, 0, 0, 0);
    run_all(50);
    chk("rst_tie_writes", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) chk("rst_tie_first", 64'(wlog[0]), 64'h30);

    // Randomized traffic against the reference
    do_reset();
    slv_rand = 1;
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 8; k++)
        add_txn(m, $urandom, $urandom, 8'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    run_all(2000);
    chk("rand_completions", 64'(done_cnt), 64'd16);
    chk("rand_writes", 64'(wlog.size()), 64'd16);
    chk("rand_aw_count", 64'(aw_cnt), 64'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
